// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_CAP,
        RMW_WAIT,
        RMW_WR,
        WR_DONE
    } state_t;

    localparam logic [3:0] WE_NONE = 4'h0;
    localparam logic [3:0] WE_ALL  = 4'hF;

    localparam logic ID_M0 = 1'b0;
    localparam logic ID_M1 = 1'b1;

endpackage

// File: rtl/ram_arbiter_byte_merge.sv
// Per-byte merge of a freshly read word with new write data.
// Byte i comes from new_word when sel[i] is set, otherwise from old_word.
module byte_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  sel,
    output logic [31:0] merged
);

    // Pick each byte lane independently from the old or the new word
    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port word RAM between the fetch
// port (m0) and the load/store port (m1). One operation in flight at a time;
// partial-byte writes are done as read-modify-write so the RAM only ever sees
// whole-word writes.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [3:0]            m0_we,
    input  logic [31:0]           m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_ack,
    output logic [31:0]           m0_rdata,

    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [3:0]            m1_we,
    input  logic [31:0]           m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_ack,
    output logic [31:0]           m1_rdata,

    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_enable,
    output logic [3:0]            ram_write_byte_enable,
    output logic [31:0]           ram_data_write,
    input  logic [31:0]           ram_data_read
);

    state_t                  state;
    logic                    last;
    logic                    cur_id;
    logic [3:0]              cur_we;
    logic [31:0]             cur_wdata;

    logic                    any_req;
    logic                    winner;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [3:0]              win_we;
    logic [31:0]             win_wdata;
    logic [31:0]             merged;

    // Choose the requester to serve: the one that did not win last time on contention
    always_comb begin
        any_req = m0_req | m1_req;
        if (m0_req && m1_req) begin
            winner = ~last;
        end else if (m1_req) begin
            winner = ID_M1;
        end else begin
            winner = ID_M0;
        end

        if (winner == ID_M1) begin
            win_addr  = m1_addr;
            win_we    = m1_we;
            win_wdata = m1_wdata;
        end else begin
            win_addr  = m0_addr;
            win_we    = m0_we;
            win_wdata = m0_wdata;
        end
    end

    byte_merge u_byte_merge (
        .old_word (ram_data_read),
        .new_word (cur_wdata),
        .sel      (cur_we),
        .merged   (merged)
    );

    // Operation sequencer: grant, RAM issue, optional read-modify-write, acknowledge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= IDLE;
            last                  <= ID_M1;
            cur_id                <= ID_M0;
            cur_we                <= WE_NONE;
            cur_wdata             <= '0;
            m0_gnt                <= 1'b0;
            m1_gnt                <= 1'b0;
            m0_ack                <= 1'b0;
            m1_ack                <= 1'b0;
            m0_rdata              <= '0;
            m1_rdata              <= '0;
            ram_address           <= '0;
            ram_enable            <= 1'b0;
            ram_write_byte_enable <= WE_NONE;
            ram_data_write        <= '0;
        end else begin
            m0_gnt <= 1'b0;
            m1_gnt <= 1'b0;
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;

            case (state)
                IDLE: begin
                    if (any_req) begin
                        last      <= winner;
                        cur_id    <= winner;
                        cur_we    <= win_we;
                        cur_wdata <= win_wdata;
                        if (winner == ID_M1) begin
                            m1_gnt <= 1'b1;
                        end else begin
                            m0_gnt <= 1'b1;
                        end
                        ram_address <= win_addr;
                        ram_enable  <= 1'b1;
                        if (win_we == WE_NONE) begin
                            ram_write_byte_enable <= WE_NONE;
                            state                 <= RD_WAIT;
                        end else if (win_we == WE_ALL) begin
                            ram_write_byte_enable <= WE_ALL;
                            ram_data_write        <= win_wdata;
                            state                 <= WR_DONE;
                        end else begin
                            ram_write_byte_enable <= WE_NONE;
                            state                 <= RMW_WAIT;
                        end
                    end
                end

                RD_WAIT: begin
                    ram_enable <= 1'b0;
                    state      <= RD_CAP;
                end

                RD_CAP: begin
                    if (cur_id == ID_M1) begin
                        m1_rdata <= ram_data_read;
                        m1_ack   <= 1'b1;
                    end else begin
                        m0_rdata <= ram_data_read;
                        m0_ack   <= 1'b1;
                    end
                    state <= IDLE;
                end

                RMW_WAIT: begin
                    ram_enable <= 1'b0;
                    state      <= RMW_WR;
                end

                RMW_WR: begin
                    ram_data_write        <= merged;
                    ram_enable            <= 1'b1;
                    ram_write_byte_enable <= WE_ALL;
                    state                 <= WR_DONE;
                end

                WR_DONE: begin
                    ram_enable            <= 1'b0;
                    ram_write_byte_enable <= WE_NONE;
                    if (cur_id == ID_M1) begin
                        m1_ack <= 1'b1;
                    end else begin
                        m0_ack <= 1'b1;
                    end
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, word-level shadow memory, and an
// arbitration model that predicts every grant from request history.
module tb_ram_arbiter;

    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic          m0_req = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [3:0]    m0_we = '0;
    logic [31:0]   m0_wdata = '0;
    logic          m0_gnt, m0_ack;
    logic [31:0]   m0_rdata;

    logic          m1_req = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [3:0]    m1_we = '0;
    logic [31:0]   m1_wdata = '0;
    logic          m1_gnt, m1_ack;
    logic [31:0]   m1_rdata;

    logic [AW-1:0] ram_address;
    logic          ram_enable;
    logic [3:0]    ram_write_byte_enable;
    logic [31:0]   ram_data_write;
    logic [31:0]   ram_data_read;

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    // Free-running clock
    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .m0_req                (m0_req),
        .m0_addr               (m0_addr),
        .m0_we                 (m0_we),
        .m0_wdata              (m0_wdata),
        .m0_gnt                (m0_gnt),
        .m0_ack                (m0_ack),
        .m0_rdata              (m0_rdata),
        .m1_req                (m1_req),
        .m1_addr               (m1_addr),
        .m1_we                 (m1_we),
        .m1_wdata              (m1_wdata),
        .m1_gnt                (m1_gnt),
        .m1_ack                (m1_ack),
        .m1_rdata              (m1_rdata),
        .ram_address           (ram_address),
        .ram_enable            (ram_enable),
        .ram_write_byte_enable (ram_write_byte_enable),
        .ram_data_write        (ram_data_write),
        .ram_data_read         (ram_data_read)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Behavioural single-port RAM: registered read, whole-word write, bench preload port
    logic [31:0]   ram_mem [0:(1<<AW)-1];
    logic [31:0]   ref_mem [0:(1<<AW)-1];
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [31:0]   pre_data = '0;
    int            ram_rd_cnt = 0;
    int            ram_wr_cnt = 0;

    always @(posedge clk) begin
        cyc++;
        if (pre_en) begin
            ram_mem[pre_addr] <= pre_data;
        end else if (ram_enable) begin
            if (ram_write_byte_enable != 4'h0) begin
                checkOutput("ram_wbe_whole_word", ram_write_byte_enable, 4'hF);
                ram_mem[ram_address] <= ram_data_write;
                ram_wr_cnt++;
            end else begin
                ram_data_read <= ram_mem[ram_address];
                ram_rd_cnt++;
            end
        end
    end

    // Arbitration model: busy from grant to ack, contention alternates, m0 first after reset
    logic [1:0]  exp_gnt = 2'b00;
    bit          busy = 1'b0;
    bit          owner = 1'b0;
    bit          model_last = 1'b1;
    int          ack_cnt [2] = '{0, 0};
    logic [31:0] exp_rdata [2] = '{32'h0, 32'h0};
    int          grant_log [$];
    int          last_gnt_cyc [2] = '{0, 0};
    int          last_ack_cyc [2] = '{0, 0};

    always @(posedge clk) begin
        if (!rst_n || busy || !(m0_req || m1_req)) begin
            exp_gnt = 2'b00;
        end else if (m0_req && m1_req) begin
            exp_gnt = model_last ? 2'b01 : 2'b10;
        end else begin
            exp_gnt = m0_req ? 2'b01 : 2'b10;
        end
        if (exp_gnt != 2'b00) begin
            busy       = 1'b1;
            owner      = exp_gnt[1];
            model_last = exp_gnt[1];
        end
    end

    // Compare grants and acks against the model away from the active edge
    always @(negedge clk) begin
        checkOutput("gnt_vector", {m1_gnt, m0_gnt}, exp_gnt);
        if (m0_gnt) grant_log.push_back(0);
        if (m1_gnt) grant_log.push_back(1);
        if (m0_ack || m1_ack) begin
            checkOutput("ack_owner", {m1_ack, m0_ack}, busy ? (owner ? 2'b10 : 2'b01) : 2'b00);
            busy = 1'b0;
        end
        if (m0_ack) ack_cnt[0]++;
        if (m1_ack) ack_cnt[1]++;
    end

    // Reset clears the model immediately, like the DUT
    always @(negedge rst_n) begin
        busy         = 1'b0;
        model_last   = 1'b1;
        exp_gnt      = 2'b00;
        exp_rdata[0] = 32'h0;
        exp_rdata[1] = 32'h0;
    end

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] we);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    task automatic preloadWord(input logic [AW-1:0] a, input logic [31:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic drivePort(input int port, input logic req, input logic [AW-1:0] a,
                             input logic [3:0] we, input logic [31:0] d);
        if (port == 0) begin
            m0_req = req; m0_addr = a; m0_we = we; m0_wdata = d;
        end else begin
            m1_req = req; m1_addr = a; m1_we = we; m1_wdata = d;
        end
    endtask

    // One transaction on one port; keep leaves req high for an immediately following op
    task automatic applyStimulus(input int port, input logic [AW-1:0] a, input logic [3:0] we,
                                 input logic [31:0] d, input bit keep);
        int          waited;
        int          lat;
        int          rd0;
        int          wr0;
        string       p;
        logic [31:0] rdata;
        p = (port == 0) ? "m0" : "m1";
        drivePort(port, 1'b1, a, we, d);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!((port == 0) ? m0_gnt : m1_gnt) && waited < 200);
        if (waited >= 200) begin
            checkOutput({p, "_gnt_timeout"}, 0, 1);
            drivePort(port, 1'b0, a, we, d);
            return;
        end
        last_gnt_cyc[port] = cyc;
        rd0 = ram_rd_cnt;
        wr0 = ram_wr_cnt;
        if (!keep) drivePort(port, 1'b0, a, we, d);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!((port == 0) ? m0_ack : m1_ack) && lat < 20);
        last_ack_cyc[port] = cyc;
        checkOutput({p, "_ack_latency"}, lat, (we == 4'h0) ? 2 : ((we == 4'hF) ? 1 : 3));
        checkOutput({p, "_ram_reads"}, ram_rd_cnt - rd0, (we == 4'hF) ? 0 : 1);
        checkOutput({p, "_ram_writes"}, ram_wr_cnt - wr0, (we == 4'h0) ? 0 : 1);
        rdata = (port == 0) ? m0_rdata : m1_rdata;
        if (we == 4'h0) begin
            exp_rdata[port] = ref_mem[a];
            checkOutput({p, "_rdata"}, rdata, exp_rdata[port]);
        end else begin
            ref_mem[a] = merge_bytes(ref_mem[a], d, we);
            checkOutput({p, "_rdata_held"}, rdata, exp_rdata[port]);
        end
    endtask

    task automatic randomTraffic(input int port, input int n);
        logic [3:0] we;
        int         sel;
        int         gap;
        for (int k = 0; k < n; k++) begin
            sel = $urandom_range(0, 2);
            if (sel == 0) we = 4'h0;
            else if (sel == 1) we = 4'hF;
            else we = 4'($urandom_range(1, 14));
            gap = $urandom_range(0, 2);
            applyStimulus(port, AW'(32'h100 + $urandom_range(0, 7)), we, $urandom,
                          (gap == 0) && (k < n - 1));
            repeat (gap) @(negedge clk);
        end
    endtask

    // Hard stop if anything ever hangs
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized two-port traffic
    initial begin
        int          waited;
        int          acks_before [2];
        logic [31:0] word;

        repeat (2) @(negedge clk);
        preloadWord(15'h0010, 32'hDEADBEEF);
        preloadWord(15'h0020, 32'hAABBCCDD);
        preloadWord(15'h0001, 32'h01010101);
        preloadWord(15'h0002, 32'h02020202);
        for (int i = 0; i < 4; i++) begin
            preloadWord(AW'(32'h40 + i), 32'h4000_0000 + i);
            preloadWord(AW'(32'h50 + i), 32'h5000_0000 + i);
        end
        for (int i = 0; i < 8; i++) preloadWord(AW'(32'h100 + i), $urandom);
        rst_n = 1'b1;

        $display("[TB] reset state");
        checkOutput("rst_gnt_ack", {m0_gnt, m1_gnt, m0_ack, m1_ack}, 4'h0);
        checkOutput("rst_ram_enable", ram_enable, 1'b0);
        checkOutput("rst_ram_wbe", ram_write_byte_enable, 4'h0);
        checkOutput("rst_ram_address", ram_address, 15'h0);
        checkOutput("rst_m0_rdata", m0_rdata, 32'h0);

        $display("[TB] single read on m0");
        applyStimulus(0, 15'h0010, 4'h0, 32'h0, 1'b0);
        checkOutput("t1_m0_rdata_value", m0_rdata, 32'hDEADBEEF);
        checkOutput("t1_m1_rdata_idle", m1_rdata, 32'h0);
        checkOutput("t1_m1_ack_count", ack_cnt[1], 0);

        $display("[TB] full-word write on m1 and read back");
        applyStimulus(1, 15'h7FFF, 4'hF, 32'h12345678, 1'b0);
        checkOutput("t2_ram_word", ram_mem[15'h7FFF], 32'h12345678);
        applyStimulus(1, 15'h7FFF, 4'h0, 32'h0, 1'b0);
        checkOutput("t2_readback", m1_rdata, 32'h12345678);

        $display("[TB] partial write via read-modify-write");
        applyStimulus(0, 15'h0020, 4'b0101, 32'h11223344, 1'b0);
        checkOutput("t3_ram_word", ram_mem[15'h0020], 32'hAA22CC44);

        $display("[TB] contention, four ops per port");
        acks_before[0] = ack_cnt[0];
        acks_before[1] = ack_cnt[1];
        fork
            begin
                for (int i = 0; i < 4; i++)
                    applyStimulus(0, AW'(32'h40 + i), (i % 2 == 1) ? 4'hF : 4'h0, 32'hA0A0_0000 + i, i < 3);
            end
            begin
                for (int i = 0; i < 4; i++)
                    applyStimulus(1, AW'(32'h50 + i), (i == 1) ? 4'b1100 : 4'h0, 32'hB0B0_0000 + i, i < 3);
            end
        join
        checkOutput("t4_m0_acks", ack_cnt[0] - acks_before[0], 4);
        checkOutput("t4_m1_acks", ack_cnt[1] - acks_before[1], 4);

        $display("[TB] back-to-back reads on m1 with req held");
        applyStimulus(1, 15'h0001, 4'h0, 32'h0, 1'b1);
        waited = last_ack_cyc[1];
        applyStimulus(1, 15'h0002, 4'h0, 32'h0, 1'b0);
        checkOutput("t6_regrant_gap", last_gnt_cyc[1] - waited, 1);
        checkOutput("t6_second_rdata", m1_rdata, 32'h02020202);

        $display("[TB] randomized traffic on both ports");
        fork
            randomTraffic(0, 20);
            randomTraffic(1, 20);
        join
        for (int i = 0; i < 8; i++) applyStimulus(i % 2, AW'(32'h100 + i), 4'h0, 32'h0, 1'b0);

        $display("[TB] reset during read-modify-write");
        preloadWord(15'h0030, 32'h55667788);
        acks_before[0] = ack_cnt[0];
        acks_before[1] = ack_cnt[1];
        drivePort(0, 1'b1, 15'h0030, 4'b0011, 32'hCAFEF00D);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!m0_gnt && waited < 20);
        checkOutput("t5_gnt", m0_gnt, 1'b1);
        drivePort(0, 1'b0, 15'h0030, 4'b0011, 32'hCAFEF00D);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_gnt_ack", {m0_gnt, m1_gnt, m0_ack, m1_ack}, 4'h0);
        checkOutput("t5_rst_ram_enable", ram_enable, 1'b0);
        checkOutput("t5_rst_ram_wbe", ram_write_byte_enable, 4'h0);
        checkOutput("t5_rst_ram_address", ram_address, 15'h0);
        checkOutput("t5_rst_ram_wdata", ram_data_write, 32'h0);
        checkOutput("t5_rst_m0_rdata", m0_rdata, 32'h0);
        checkOutput("t5_rst_m1_rdata", m1_rdata, 32'h0);
        repeat (3) @(negedge clk);
        checkOutput("t5_no_ack", (ack_cnt[0] - acks_before[0]) + (ack_cnt[1] - acks_before[1]), 0);
        word = ram_mem[15'h0030];
        checkOutput("t5_word_untouched", word, 32'h55667788);
        rst_n = 1'b1;
        grant_log.delete();
        fork
            applyStimulus(0, 15'h0030, 4'h0, 32'h0, 1'b0);
            applyStimulus(1, 15'h0010, 4'h0, 32'h0, 1'b0);
        join
        checkOutput("t5_first_grant_m0", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
        checkOutput("t5_m0_read_old", m0_rdata, 32'h55667788);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
